// File: rtl/raz_pulse_gen.sv
// rtl/raz_pulse_gen.sv - RAZ_CHN pulse generator with hold-off, busy flag and issued/dropped counters
// Turns delayed-trigger or software RAZ requests into one fixed-width pulse each.
module raz_pulse_gen #(
  parameter int unsigned W0_CYCLES      = 3,
  parameter int unsigned W1_CYCLES      = 10,
  parameter int unsigned W2_CYCLES      = 20,
  parameter int unsigned W3_CYCLES      = 40,
  parameter int unsigned HOLDOFF_CYCLES = 4,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                 Clk,
  input  logic                 reset_n,
  input  logic                 ExternalRaz_en,
  input  logic                 SingleRaz_en,
  input  logic                 ForceRaz,
  input  logic [1:0]           RazWidthSel,
  input  logic                 CountClear,
  output logic                 Raz_Chn,
  output logic                 RazBusy,
  output logic [CNT_WIDTH-1:0] RazCount,
  output logic [CNT_WIDTH-1:0] DropCount
);

  localparam logic [7:0] W0_M1   = 8'(W0_CYCLES - 1);
  localparam logic [7:0] W1_M1   = 8'(W1_CYCLES - 1);
  localparam logic [7:0] W2_M1   = 8'(W2_CYCLES - 1);
  localparam logic [7:0] W3_M1   = 8'(W3_CYCLES - 1);
  localparam logic [7:0] HOLD_M1 = 8'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 raz_q, raz_d;
  logic                 force_q;
  logic [CNT_WIDTH-1:0] raz_cnt_q, raz_cnt_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                 req;
  logic                 issue;
  logic                 drop;
  logic [7:0]           width_m1;

  // Both sources merge into one request, so coincident ones never double-count.
  assign req = (SingleRaz_en & ExternalRaz_en) | (ForceRaz & ~force_q);

  always_comb begin
    width_m1 = W0_M1;
    case (RazWidthSel)
      2'd0:    width_m1 = W0_M1;
      2'd1:    width_m1 = W1_M1;
      2'd2:    width_m1 = W2_M1;
      default: width_m1 = W3_M1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    raz_d   = raz_q;
    issue   = 1'b0;
    drop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_PULSE;
          cnt_d   = width_m1;
          raz_d   = 1'b1;
          issue   = 1'b1;
        end
      end
      ST_PULSE: begin
        drop = req;
        if (cnt_q == 8'd0) begin
          state_d = ST_HOLDOFF;
          cnt_d   = HOLD_M1;
          raz_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HOLDOFF: begin
        drop = req;
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        raz_d   = 1'b0;
      end
    endcase
  end

  // Clear beats a same-cycle increment; the drop counter sticks at all-ones.
  always_comb begin
    raz_cnt_d  = raz_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (CountClear) begin
      raz_cnt_d  = '0;
      drop_cnt_d = '0;
    end else begin
      if (issue) begin
        raz_cnt_d = raz_cnt_q + 1'b1;
      end
      if (drop && (drop_cnt_q != '1)) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end
  end

  // force_q resets high so a ForceRaz level held through reset is not an edge.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      raz_q      <= 1'b0;
      force_q    <= 1'b1;
      raz_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      raz_q      <= raz_d;
      force_q    <= ForceRaz;
      raz_cnt_q  <= raz_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign Raz_Chn   = raz_q;
  assign RazBusy   = (state_q != ST_IDLE);
  assign RazCount  = raz_cnt_q;
  assign DropCount = drop_cnt_q;

endmodule

// File: tb/tb_raz_pulse_gen.sv
// tb/tb_raz_pulse_gen.sv - self-checking bench for raz_pulse_gen against a cycle-interval reference model
// Built with CNT_WIDTH=4 so counter wrap and saturation are reachable quickly.
module tb_raz_pulse_gen;

  localparam int CW   = 4;
  localparam int HOLD = 4;

  logic          Clk;
  logic          reset_n;
  logic          ExternalRaz_en;
  logic          SingleRaz_en;
  logic          ForceRaz;
  logic [1:0]    RazWidthSel;
  logic          CountClear;
  logic          Raz_Chn;
  logic          RazBusy;
  logic [CW-1:0] RazCount;
  logic [CW-1:0] DropCount;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: each accepted request reserves a time window in cycle numbers.
  int cyc      = 0;
  int p_start  = 0;
  int p_end    = -1;
  int free_at  = 0;
  int m_cnt    = 0;
  int m_drop   = 0;
  bit m_prevf  = 1'b1;

  raz_pulse_gen #(
    .W0_CYCLES(3), .W1_CYCLES(10), .W2_CYCLES(20), .W3_CYCLES(40),
    .HOLDOFF_CYCLES(HOLD), .CNT_WIDTH(CW)
  ) dut (
    .Clk(Clk), .reset_n(reset_n), .ExternalRaz_en(ExternalRaz_en),
    .SingleRaz_en(SingleRaz_en), .ForceRaz(ForceRaz), .RazWidthSel(RazWidthSel),
    .CountClear(CountClear), .Raz_Chn(Raz_Chn), .RazBusy(RazBusy),
    .RazCount(RazCount), .DropCount(DropCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic int width_of(input logic [1:0] s);
    case (s)
      2'd0:    return 3;
      2'd1:    return 10;
      2'd2:    return 20;
      default: return 40;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    p_start = 0; p_end = -1; free_at = 0;
    m_cnt = 0; m_drop = 0; m_prevf = 1'b1;
  endtask

  task automatic model_eval();
    bit req;
    int w;
    req = (SingleRaz_en & ExternalRaz_en) | (ForceRaz & ~m_prevf);
    m_prevf = ForceRaz;
    if (req && (cyc >= free_at)) begin
      w       = width_of(RazWidthSel);
      p_start = cyc + 1;
      p_end   = cyc + w;
      free_at = cyc + w + HOLD + 1;
      m_cnt   = (m_cnt + 1) % (1 << CW);
    end else if (req && (m_drop < (1 << CW) - 1)) begin
      m_drop++;
    end
    if (CountClear) begin
      m_cnt = 0; m_drop = 0;
    end
  endtask

  task automatic check_all();
    chk("raz_chn",   32'(Raz_Chn),   32'((cyc >= p_start) && (cyc <= p_end)));
    chk("raz_busy",  32'(RazBusy),   32'((cyc >= p_start) && (cyc < free_at)));
    chk("raz_count", 32'(RazCount),  32'(m_cnt));
    chk("drop_count",32'(DropCount), 32'(m_drop));
  endtask

  task automatic step();
    model_eval();
    @(posedge Clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int c0;
    int d0;
    reset_n = 1'b0; ExternalRaz_en = 1'b0; SingleRaz_en = 1'b0; ForceRaz = 1'b0;
    RazWidthSel = 2'd0; CountClear = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    model_reset();
    check_all();
    reset_n = 1'b1;
    steps(3);

    // Width select 1: 10-cycle pulse, idle again 15 cycles after request
    ExternalRaz_en = 1'b1; RazWidthSel = 2'd1; SingleRaz_en = 1'b1;
    step();
    chk("t1_start", 32'(Raz_Chn), 32'd1);
    SingleRaz_en = 1'b0;
    steps(9);
    chk("t1_last_high", 32'(Raz_Chn), 32'd1);
    steps(5);
    chk("t1_busy_low", 32'(RazBusy), 32'd0);
    chk("t1_count", 32'(RazCount), 32'd1);

    // Enable gating, then ForceRaz edge
    ExternalRaz_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      SingleRaz_en = 1'b1; step();
      SingleRaz_en = 1'b0; step();
    end
    chk("t2_gated_count", 32'(RazCount), 32'd1);
    chk("t2_gated_drop", 32'(DropCount), 32'd0);
    ForceRaz = 1'b1;
    steps(40);
    chk("t2_force_once", 32'(RazCount), 32'd2);
    ForceRaz = 1'b0;
    steps(2);

    // Busy drop, then request in first idle cycle
    ExternalRaz_en = 1'b1; RazWidthSel = 2'd0;
    d0 = m_drop;
    SingleRaz_en = 1'b1; step();
    SingleRaz_en = 1'b0; step();
    SingleRaz_en = 1'b1; step();
    SingleRaz_en = 1'b0; steps(5);
    chk("t3_drop", 32'(DropCount), 32'(d0 + 1));
    SingleRaz_en = 1'b1; step();
    chk("t3_repulse", 32'(Raz_Chn), 32'd1);
    SingleRaz_en = 1'b0; steps(10);

    // Coincident sources, mid-pulse select change
    c0 = m_cnt; d0 = m_drop;
    RazWidthSel = 2'd3; SingleRaz_en = 1'b1; ForceRaz = 1'b1;
    step();
    SingleRaz_en = 1'b0;
    steps(5);
    RazWidthSel = 2'd0;
    steps(34);
    chk("t4_still_high", 32'(Raz_Chn), 32'd1);
    step();
    chk("t4_fell", 32'(Raz_Chn), 32'd0);
    chk("t4_one_count", 32'(RazCount), 32'((c0 + 1) % 16));
    chk("t4_no_drop", 32'(DropCount), 32'(d0));
    ForceRaz = 1'b0;
    steps(6);

    // Reset mid-pulse with ForceRaz held high
    RazWidthSel = 2'd3; ForceRaz = 1'b1;
    steps(5);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge Clk);
    #1;
    check_all();
    reset_n = 1'b1;
    steps(10);
    chk("t5_no_pulse", 32'(RazCount), 32'd0);
    ForceRaz = 1'b0;
    steps(2);

    // Counter wrap, drop saturation, clear priority
    RazWidthSel = 2'd0;
    for (int i = 0; i < 17; i++) begin
      SingleRaz_en = 1'b1; step();
      SingleRaz_en = 1'b0; steps(8);
    end
    chk("t6_wrap", 32'(RazCount), 32'd1);
    RazWidthSel = 2'd3;
    SingleRaz_en = 1'b1;
    steps(21);
    chk("t6_saturate", 32'(DropCount), 32'd15);
    SingleRaz_en = 1'b0;
    steps(30);
    SingleRaz_en = 1'b1; CountClear = 1'b1;
    step();
    chk("t6_clear_cnt", 32'(RazCount), 32'd0);
    chk("t6_clear_drop", 32'(DropCount), 32'd0);
    chk("t6_clear_pulse", 32'(Raz_Chn), 32'd1);
    SingleRaz_en = 1'b0; CountClear = 1'b0;
    steps(50);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      ExternalRaz_en = ($urandom_range(0, 3) != 0);
      SingleRaz_en   = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) ForceRaz = ~ForceRaz;
      RazWidthSel    = 2'($urandom_range(0, 3));
      CountClear     = ($urandom_range(0, 60) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
